// File: rtl/braille_converter.sv
// braille_converter
//   Collects an ASCII message over a valid/ready handshake, translates each
//   byte into a 6-dot braille cell (capital / number indicators inserted), then
//   bursts the buffered message to the braille reader:
//   one announce cycle (cell 0, size), then cells 0..count-1 back-to-back.
//
// Ports
//   clk, reset (async, active-low)
//   ascii_in[7:0], ascii_valid, ascii_ready : character handshake
//   msg_end                                 : one-cycle message terminator
//   braille_out[7:0], braille_size[7:0],
//   braille_valid                           : burst to the reader
//   busy                                    : high outside COLLECT
//   unsupported                             : sticky unmapped-character flag
//
// Optional build macro
//   NEWLINE_TERM_EN : accepted LF/CR acts as msg_end instead of being stored.
//
// state    | meaning
// COLLECT  | accept characters, wait for end of message
// SECOND   | write the held second cell of a two-cell character
// ANNOUNCE | first valid cycle: size + cell 0, sink leaves IDLE
// STREAM   | cells 0..count-1, one per cycle
// CLEAR    | outputs low, count / number mode / unsupported cleared
module braille_converter #(
  parameter int MAX_CELLS = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] ascii_in,
  input  logic       ascii_valid,
  output logic       ascii_ready,
  input  logic       msg_end,
  output logic [7:0] braille_out,
  output logic [7:0] braille_size,
  output logic       braille_valid,
  output logic       busy,
  output logic       unsupported
);

  localparam int AW = (MAX_CELLS > 1) ? $clog2(MAX_CELLS) : 1;
  localparam logic [7:0] LIM_READY = 8'(MAX_CELLS - 2);
  localparam logic [7:0] LIM_FULL  = 8'(MAX_CELLS - 1);

  typedef enum logic [2:0] {COLLECT, SECOND, ANNOUNCE, STREAM, CLEAR} state_t;

  state_t      state, state_n;
  logic [7:0]  count, count_n, k, k_n, cnt_after;
  logic        num_mode, num_n, unsup_n, pend, pend_n;
  logic [5:0]  held, held_n;
  logic [5:0]  cells [MAX_CELLS];
  logic        wr_en;
  logic [5:0]  wr_data;

  logic [5:0]  c_first, c_second, digit_cell;
  logic        c_two, c_unsup, c_digit, nl_hit, accept, end_req;
  logic [4:0]  letter_idx, digit_idx;

  function automatic logic [5:0] letter_cell(input logic [4:0] idx);
    case (idx)
      5'd0:  return 6'h01;  5'd1:  return 6'h03;  5'd2:  return 6'h09;
      5'd3:  return 6'h19;  5'd4:  return 6'h11;  5'd5:  return 6'h0B;
      5'd6:  return 6'h1B;  5'd7:  return 6'h13;  5'd8:  return 6'h0A;
      5'd9:  return 6'h1A;  5'd10: return 6'h05;  5'd11: return 6'h07;
      5'd12: return 6'h0D;  5'd13: return 6'h1D;  5'd14: return 6'h15;
      5'd15: return 6'h0F;  5'd16: return 6'h1F;  5'd17: return 6'h17;
      5'd18: return 6'h0E;  5'd19: return 6'h1E;  5'd20: return 6'h25;
      5'd21: return 6'h27;  5'd22: return 6'h3A;  5'd23: return 6'h2D;
      5'd24: return 6'h3D;  5'd25: return 6'h35;
      default: return 6'h3F;
    endcase
  endfunction

  // Character classification; letters of both cases share the low 5 bits.
  always_comb begin
    letter_idx = ascii_in[4:0] - 5'd1;
    digit_idx  = (ascii_in[3:0] == 4'd0) ? 5'd9 : {1'b0, ascii_in[3:0] - 4'd1};
    digit_cell = letter_cell(digit_idx);
    c_first    = 6'h3F;
    c_second   = 6'h00;
    c_two      = 1'b0;
    c_unsup    = 1'b0;
    c_digit    = 1'b0;
    nl_hit     = 1'b0;
    if (ascii_in >= 8'h61 && ascii_in <= 8'h7A) begin
      c_first = letter_cell(letter_idx);
    end else if (ascii_in >= 8'h41 && ascii_in <= 8'h5A) begin
      c_first  = 6'h20;
      c_second = letter_cell(letter_idx);
      c_two    = 1'b1;
    end else if (ascii_in >= 8'h30 && ascii_in <= 8'h39) begin
      c_digit = 1'b1;
      if (!num_mode) begin
        c_first  = 6'h3C;
        c_second = digit_cell;
        c_two    = 1'b1;
      end else begin
        c_first = digit_cell;
      end
    end else begin
      case (ascii_in)
        8'h20:   c_first = 6'h00;
        8'h2C:   c_first = 6'h02;
        8'h2E:   c_first = 6'h32;
        8'h3F:   c_first = 6'h26;
        8'h21:   c_first = 6'h16;
        8'h27:   c_first = 6'h04;
        8'h2D:   c_first = 6'h24;
        default: c_unsup = 1'b1;
      endcase
    end
`ifdef NEWLINE_TERM_EN
    nl_hit = (ascii_in == 8'h0A) || (ascii_in == 8'h0D);
`else
    nl_hit = 1'b0;
`endif
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= COLLECT;
      count       <= 8'd0;
      k           <= 8'd0;
      num_mode    <= 1'b0;
      unsupported <= 1'b0;
      pend        <= 1'b0;
      held        <= 6'h00;
    end else begin
      state       <= state_n;
      count       <= count_n;
      k           <= k_n;
      num_mode    <= num_n;
      unsupported <= unsup_n;
      pend        <= pend_n;
      held        <= held_n;
    end
  end

  // Buffer contents need no reset: count gates what is ever read.
  always_ff @(posedge clk) begin
    if (wr_en) cells[count[AW-1:0]] <= wr_data;
  end

  always_comb begin
    state_n       = state;
    count_n       = count;
    k_n           = k;
    num_n         = num_mode;
    unsup_n       = unsupported;
    pend_n        = pend;
    held_n        = held;
    wr_en         = 1'b0;
    wr_data       = 6'h00;
    ascii_ready   = 1'b0;
    busy          = 1'b1;
    braille_valid = 1'b0;
    braille_size  = 8'd0;
    braille_out   = 8'd0;
    accept        = 1'b0;
    end_req       = 1'b0;
    cnt_after     = count;
    case (state)
      COLLECT: begin
        busy        = 1'b0;
        ascii_ready = (count <= LIM_READY);
        accept      = ascii_valid && ascii_ready;
        end_req     = msg_end;
        if (accept && nl_hit) begin
          end_req = 1'b1;
        end else if (accept) begin
          wr_en     = 1'b1;
          wr_data   = c_first;
          cnt_after = count + 8'd1;
          num_n     = c_digit;
          if (c_unsup) unsup_n = 1'b1;
        end
        count_n = cnt_after;
        if (accept && !nl_hit && c_two) begin
          // End arriving with a two-cell character is taken from SECOND.
          held_n  = c_second;
          pend_n  = msg_end;
          state_n = SECOND;
        end else if ((end_req && cnt_after != 8'd0) || cnt_after >= LIM_FULL) begin
          state_n = ANNOUNCE;
        end
      end
      SECOND: begin
        wr_en   = 1'b1;
        wr_data = held;
        count_n = count + 8'd1;
        pend_n  = 1'b0;
        state_n = (pend || count_n >= LIM_FULL) ? ANNOUNCE : COLLECT;
      end
      ANNOUNCE: begin
        braille_valid = 1'b1;
        braille_size  = count;
        braille_out   = {2'b00, cells[0]};
        k_n           = 8'd0;
        state_n       = STREAM;
      end
      STREAM: begin
        braille_valid = 1'b1;
        braille_size  = count;
        braille_out   = {2'b00, cells[k[AW-1:0]]};
        if (k == count - 8'd1) state_n = CLEAR;
        else                   k_n     = k + 8'd1;
      end
      CLEAR: begin
        count_n = 8'd0;
        num_n   = 1'b0;
        unsup_n = 1'b0;
        state_n = COLLECT;
      end
      default: state_n = COLLECT;
    endcase
  end

endmodule

// File: tb/tb_braille_converter.sv
module tb_braille_converter;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] ascii_in;
  logic       ascii_valid;
  logic       ascii_ready;
  logic       msg_end;
  logic [7:0] braille_out;
  logic [7:0] braille_size;
  logic       braille_valid;
  logic       busy;
  logic       unsupported;

  int vectors = 0;
  int miscompares = 0;

  // Expected burst beats: {size, cell}, announce cycle included.
  logic [15:0] exp_q[$];

  braille_converter #(.MAX_CELLS(8)) dut (
    .clk(clk), .reset(reset),
    .ascii_in(ascii_in), .ascii_valid(ascii_valid), .ascii_ready(ascii_ready),
    .msg_end(msg_end),
    .braille_out(braille_out), .braille_size(braille_size),
    .braille_valid(braille_valid), .busy(busy), .unsupported(unsupported)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset && braille_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL burst_extra: got out=%h size=%0d, required no valid beat", braille_out, braille_size);
      end else begin
        logic [15:0] e;
        e = exp_q.pop_front();
        if (braille_out !== e[7:0] || braille_size !== e[15:8]) begin
          miscompares++;
          $display("FAIL burst_beat: got out=%h size=%0d, required out=%h size=%0d",
                   braille_out, braille_size, e[7:0], e[15:8]);
        end
      end
    end
  end

  task automatic push_burst(input logic [7:0] size, input logic [7:0] c0, input logic [7:0] c1,
                            input logic [7:0] c2, input logic [7:0] c3, input logic [7:0] c4);
    logic [7:0] c [5];
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3; c[4] = c4;
    exp_q.push_back({size, c[0]});
    for (int i = 0; i < int'(size) && i < 5; i++) exp_q.push_back({size, c[i]});
  endtask

  task automatic send_char(input logic [7:0] c, input logic e);
    int n = 0;
    ascii_in = c; ascii_valid = 1'b1; msg_end = e;
    while (!ascii_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (n >= 50) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: ascii_ready=%b, required 1 within 50 cycles", ascii_ready);
    end
    @(posedge clk); #1;
    ascii_valid = 1'b0; msg_end = 1'b0;
  endtask

  task automatic pulse_end();
    msg_end = 1'b1;
    @(posedge clk); #1;
    msg_end = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || exp_q.size() != 0) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    vectors++;
    if (n >= 200) begin
      miscompares++;
      $display("FAIL burst_drain: %0d beats still expected, busy=%b, required 0 and 0", exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; ascii_in = 8'h00; ascii_valid = 1'b0; msg_end = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if ({braille_valid, braille_out, braille_size, busy, unsupported} !== 19'd0) begin
      miscompares++;
      $display("FAIL reset_outputs: got valid=%b out=%h size=%h busy=%b unsup=%b, required all 0",
               braille_valid, braille_out, braille_size, busy, unsupported);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    vectors++;
    if (ascii_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: got ready=%b busy=%b, required 1 0", ascii_ready, busy);
    end
  endtask

  task automatic test_lowercase();
    int busy_n = 0, valid_n = 0;
    logic unsup_seen = 1'b0;
    push_burst(8'd2, 8'h01, 8'h03, 8'h00, 8'h00, 8'h00);
    send_char("a", 1'b0);
    send_char("b", 1'b0);
    pulse_end();
    for (int i = 0; i < 12; i++) begin
      if (busy) busy_n++;
      if (braille_valid) valid_n++;
      if (unsupported) unsup_seen = 1'b1;
      @(posedge clk); #1;
    end
    vectors++;
    if (busy_n != 4 || valid_n != 3 || unsup_seen !== 1'b0) begin
      miscompares++;
      $display("FAIL ab_framing: got busy=%0d valid=%0d unsup=%b, required 4 3 0", busy_n, valid_n, unsup_seen);
    end
    wait_idle();
  endtask

  task automatic test_capital();
    push_burst(8'd3, 8'h20, 8'h13, 8'h0A, 8'h00, 8'h00);
    send_char("H", 1'b0);
    vectors++;
    if (ascii_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL cap_ready_second: got %b, required 0", ascii_ready);
    end
    @(posedge clk); #1;
    vectors++;
    if (ascii_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL cap_ready_back: got %b, required 1", ascii_ready);
    end
    send_char("i", 1'b0);
    pulse_end();
    wait_idle();
  endtask

  task automatic test_digits();
    push_burst(8'd5, 8'h01, 8'h3C, 8'h01, 8'h03, 8'h03);
    send_char("a", 1'b0);
    send_char("1", 1'b0);
    send_char("2", 1'b0);
    send_char("b", 1'b0);
    pulse_end();
    wait_idle();
  endtask

  task automatic test_autoterm();
    for (int i = 0; i < 8; i++) exp_q.push_back({8'd7, 8'h01});
    ascii_in = "a"; ascii_valid = 1'b1;
    for (int i = 0; i < 7; i++) begin
      vectors++;
      if (ascii_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL auto_ready_%0d: got %b, required 1", i, ascii_ready);
      end
      @(posedge clk); #1;
    end
    vectors++;
    if (ascii_ready !== 1'b0 || braille_valid !== 1'b1 || braille_size !== 8'd7) begin
      miscompares++;
      $display("FAIL auto_term: got ready=%b valid=%b size=%0d, required 0 1 7",
               ascii_ready, braille_valid, braille_size);
    end
    ascii_valid = 1'b0;
    wait_idle();
  endtask

  task automatic test_unsupported_end_with_char();
    logic unsup_burst = 1'b1;
    push_burst(8'd3, 8'h3F, 8'h20, 8'h35, 8'h00, 8'h00);
    send_char("#", 1'b0);
    vectors++;
    if (unsupported !== 1'b1) begin
      miscompares++;
      $display("FAIL unsup_set: got %b, required 1", unsupported);
    end
    send_char("Z", 1'b1);
    @(posedge clk); #1;
    while (busy && braille_valid) begin
      if (unsupported !== 1'b1) unsup_burst = 1'b0;
      @(posedge clk); #1;
    end
    vectors++;
    if (unsup_burst !== 1'b1) begin
      miscompares++;
      $display("FAIL unsup_burst: flag dropped during burst, required 1 throughout");
    end
    wait_idle();
    vectors++;
    if (unsupported !== 1'b0) begin
      miscompares++;
      $display("FAIL unsup_clear: got %b, required 0", unsupported);
    end
  endtask

  task automatic test_newline();
`ifdef NEWLINE_TERM_EN
    push_burst(8'd1, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    send_char("a", 1'b0);
    send_char(8'h0A, 1'b0);
`else
    push_burst(8'd1, 8'h3F, 8'h00, 8'h00, 8'h00, 8'h00);
    send_char(8'h0A, 1'b0);
    pulse_end();
`endif
    wait_idle();
  endtask

  task automatic test_empty_end();
    int busy_n = 0;
    pulse_end();
    for (int i = 0; i < 5; i++) begin
      if (busy || braille_valid) busy_n++;
      @(posedge clk); #1;
    end
    vectors++;
    if (busy_n != 0) begin
      miscompares++;
      $display("FAIL empty_end: got %0d busy cycles, required 0", busy_n);
    end
  endtask

  task automatic test_reset_midstream();
    exp_q.push_back({8'd3, 8'h01});
    exp_q.push_back({8'd3, 8'h01});
    send_char("a", 1'b0);
    send_char("b", 1'b0);
    send_char("c", 1'b0);
    pulse_end();
    @(posedge clk);
    @(negedge clk); #1;
    reset = 1'b0;
    #1;
    vectors++;
    if (braille_valid !== 1'b0 || braille_size !== 8'd0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_reset: got valid=%b size=%0d busy=%b, required 0 0 0",
               braille_valid, braille_size, busy);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL abort_beats: %0d beats missing before reset, required 0", exp_q.size());
      exp_q.delete();
    end
    push_burst(8'd1, 8'h2D, 8'h00, 8'h00, 8'h00, 8'h00);
    send_char("x", 1'b1);
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_lowercase();
    test_capital();
    test_digits();
    test_autoterm();
    test_unsupported_end_with_char();
    test_newline();
    test_empty_end();
    test_reset_midstream();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/braille_converter.md
Name: braille_converter

Overview:
- Upstream producer for the braille reader stage. Accepts an ASCII byte stream over a valid/ready handshake and translates each byte into a 6-dot braille cell, inserting capital and number indicators where needed.
- Buffers a whole message, then bursts it out as braille_out/braille_size/braille_valid in exactly the framing the reader's IDLE→LOADING capture expects.

Parameters:
- MAX_CELLS, 255, buffer depth in cells; legal range 4..255 because braille_size is 8-bit.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- ascii_in  in  8  ASCII character
- ascii_valid  in  1  ascii_in is valid this cycle
- ascii_ready  out  1  converter accepts a character this cycle
- msg_end  in  1  single-cycle pulse that terminates the current message
- braille_out  out  8  cell pattern; bit n-1 = dot n, bits 7:6 = 0
- braille_size  out  8  number of cells in the burst
- braille_valid  out  1  burst framing strobe
- busy  out  1  high in every state except COLLECT
- unsupported  out  1  sticky: message contained an unmapped character

Behaviour:
- Reset values: all outputs 0, cell count 0, number mode 0, state COLLECT.
- Reset asserted mid-burst aborts the burst immediately and discards buffer contents.
- Character transfer happens when ascii_valid & ascii_ready. ascii_ready = (state==COLLECT) & (count <= MAX_CELLS-2), so a two-cell character always fits.
- Character map:
  - Letters a..j = 01,03,09,19,11,0B,1B,13,0A,1A (hex). k..t = a..j | 04. u,v,x,y,z = 25,27,2D,3D,35. w = 3A.
  - Uppercase: capital indicator 20, then the lowercase cell.
  - Digits 1..9,0 use the cells of a..j. Number indicator 3C is emitted only when number mode is 0; emitting it sets number mode. Any non-digit clears number mode.
  - space=00, ','=02, '.'=32, '?'=26, '!'=16, '\''=04, '-'=24.
  - Any other byte writes 3F and sets unsupported.
- Write timing: the first cell is written in the accept cycle. For a two-cell character the second cell is written in the SECOND state on the next cycle, with ascii_ready=0 during that cycle.
- States:
  - COLLECT: accept characters as above.
    - Two-cell character → SECOND.
    - msg_end with count>0 (or count reaching MAX_CELLS-1 or more after a write) → ANNOUNCE.
    - msg_end with count==0 is ignored.
    - msg_end together with an accepted character: the character is written first, then → ANNOUNCE; for a two-cell character the end is held pending and taken from SECOND.
  - SECOND: write the held cell, then → ANNOUNCE if an end is pending or count ≥ MAX_CELLS-1, otherwise → COLLECT.
  - ANNOUNCE (1 cycle, registered outputs): braille_valid=1, braille_size=count, braille_out=buf[0]. → STREAM with k=0.
  - STREAM (count cycles): braille_valid=1, braille_out=buf[k], braille_size held, k increments each cycle. After k=count-1 → CLEAR.
  - CLEAR (1 cycle): braille_valid=0, braille_out=0, braille_size=0. Count, number mode and unsupported are cleared. → COLLECT.
- Burst length is exactly count+1 valid cycles with braille_size stable throughout. The announce cycle is the one the sink spends leaving IDLE; cells 0..count-1 follow back-to-back.
- msg_end and ascii_valid are ignored while busy.
- No flow control toward the sink: the sink must be idle when a burst starts.

Optional Feature:
- Macro: NEWLINE_TERM_EN.
- Defined: an accepted byte 0x0A (LF) or 0x0D (CR) is not written to the buffer; it behaves exactly like a msg_end pulse in that cycle, including the count==0 ignore rule.
- Undefined: 0x0A and 0x0D are unmapped and write 3F, setting unsupported.

Test Plan:
- Reset then "ab", msg_end → 3 valid cycles, size=2, outs 01,01,03; busy high for 4 cycles; unsupported=0.
- "Hi" + msg_end → size=3, cells 20,13,0A; ascii_ready low exactly one cycle after 'H'.
- "a12b" + msg_end → cells 01,3C,01,03,03 (size 5); a single number indicator only.
- Feed 'a' continuously with MAX_CELLS=8 → auto-terminate at count 7, size=7; ascii_ready deasserts at count 7.
- '#' then msg_end together with 'Z' in the same cycle → cells 3F,20,35, size 3, unsupported=1 during the burst, then 0 after CLEAR.
- msg_end with empty buffer → no burst. Reset asserted mid-STREAM → braille_valid=0 immediately and next message starts from count 0.
